// File: rtl/lstm_row_pkg.sv
// Shared definitions for the LSTM row-buffer sequencer: FSM state encoding and
// counter sizing helper.
package lstm_row_pkg;

  typedef logic [2:0] row_state_t;

  localparam row_state_t ST_IDLE      = 3'd0;
  localparam row_state_t ST_FILL      = 3'd1;
  localparam row_state_t ST_WAIT_FULL = 3'd2;
  localparam row_state_t ST_DRAIN     = 3'd3;
  localparam row_state_t ST_WAIT_DONE = 3'd4;

  // One extra bit so a counter can hold MEM_SIZE == 2**addr_width.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bram_row_sequencer_if.sv
// Bus bundle around bram_row_sequencer: upstream word stream, row-buffer
// write/read ports and the downstream MAC-side stream.
interface bram_row_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_din;
  logic                  buf_we;
  logic                  buf_reset_done;
  logic                  buf_done;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic                  buf_rd_en;
  logic [DATA_WIDTH-1:0] buf_dout;
  logic                  buf_read_done;

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  s_valid, s_data, buf_done, buf_dout, buf_read_done, m_ready,
    output s_ready, buf_addr, buf_din, buf_we, buf_reset_done,
           buf_rd_addr, buf_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, buf_done, buf_dout, buf_read_done, m_ready,
    input  s_ready, buf_addr, buf_din, buf_we, buf_reset_done,
           buf_rd_addr, buf_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/row_seq_out_slot.sv
// Single-entry registered output slot toward the MAC array. can_load_o tells
// the reader a new word may enter this cycle without dropping the held one.
module row_seq_out_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  can_load_o
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  assign can_load_o = !valid_q || ready_i;

  // Load has priority over a plain accept; data only changes on load so it
  // stays stable while the consumer stalls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
      last_d  = last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/bram_row_sequencer.sv
// Master-side controller for one row buffer: fills it from a stream, waits for
// full, then drains it into a registered output stream. Optional watchdog on
// the two wait states is enabled with ROW_SEQ_TIMEOUT_EN.
module bram_row_sequencer
  import lstm_row_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_SIZE   = 4
`ifdef ROW_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  bram_row_sequencer_if.master bus,
  output logic                 busy,
  output logic                 row_done,
  output logic                 err
);
  localparam int               CNT_W  = cnt_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MEM_SIZE - 1);

  row_state_t       state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_done_seen_q, rd_done_seen_d;
  logic             row_done_q;

  logic             s_ready_s, rd_en_s, wr_fire_s, can_load_s;
  logic             accept_start_s, done_exit_s, timeout_s;
  logic             slot_valid_s, slot_last_s;
  logic [DATA_WIDTH-1:0] slot_data_s;

  assign accept_start_s = (state_q == ST_IDLE) && start;
  assign wr_fire_s      = s_ready_s && bus.s_valid;
  // Leaving WAIT_DONE needs the latched read-complete and an empty/draining slot.
  assign done_exit_s    = (state_q == ST_WAIT_DONE) && rd_done_seen_q && can_load_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; normal progress wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FILL;
        else       state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (wr_fire_s && (wr_cnt_q == LAST_C)) state_d = ST_WAIT_FULL;
        else                                    state_d = ST_FILL;
      end
      ST_WAIT_FULL: begin
        if (bus.buf_done)   state_d = ST_DRAIN;
        else if (timeout_s) state_d = ST_IDLE;
        else                state_d = ST_WAIT_FULL;
      end
      ST_DRAIN: begin
        if (rd_en_s && (rd_cnt_q == LAST_C)) state_d = ST_WAIT_DONE;
        else                                  state_d = ST_DRAIN;
      end
      ST_WAIT_DONE: begin
        if (done_exit_s || timeout_s) state_d = ST_IDLE;
        else                          state_d = ST_WAIT_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: input ready in FILL, read strobe in DRAIN gated by the slot.
  always_comb begin
    s_ready_s = 1'b0;
    rd_en_s   = 1'b0;
    case (state_q)
      ST_FILL:  s_ready_s = 1'b1;
      ST_DRAIN: rd_en_s   = (rd_cnt_q < SIZE_C) && can_load_s;
      default: begin
        s_ready_s = 1'b0;
        rd_en_s   = 1'b0;
      end
    endcase
  end

  // Write/read counters and the sticky read-complete flag.
  always_comb begin
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    rd_done_seen_d = rd_done_seen_q;
    if (accept_start_s) begin
      wr_cnt_d       = '0;
      rd_cnt_d       = '0;
      rd_done_seen_d = 1'b0;
    end else begin
      if (wr_fire_s) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      else           wr_cnt_d = wr_cnt_q;
      if (rd_en_s)   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      else           rd_cnt_d = rd_cnt_q;
      if (bus.buf_read_done &&
          ((state_q == ST_DRAIN) || (state_q == ST_WAIT_DONE))) rd_done_seen_d = 1'b1;
      else                                                      rd_done_seen_d = rd_done_seen_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      rd_done_seen_q <= 1'b0;
      row_done_q     <= 1'b0;
    end else begin
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_done_seen_q <= rd_done_seen_d;
      row_done_q     <= done_exit_s;
    end
  end

`ifdef ROW_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            in_wait_s;

  assign in_wait_s = (state_q == ST_WAIT_FULL) || (state_q == ST_WAIT_DONE);
  assign timeout_s = in_wait_s && (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                     !((state_q == ST_WAIT_FULL) && bus.buf_done) && !done_exit_s;

  // Watchdog restarts on every state change so each wait state gets a full budget.
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (!in_wait_s || (state_d != state_q)) wd_d = '0;
    else                                    wd_d = wd_q + WD_W'(1);
    if (accept_start_s) err_d = 1'b0;
    else if (timeout_s) err_d = 1'b1;
    else                err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  row_seq_out_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (timeout_s),
    .load_i     (rd_en_s),
    .data_i     (bus.buf_dout),
    .last_i     (rd_cnt_q == LAST_C),
    .ready_i    (bus.m_ready),
    .valid_o    (slot_valid_s),
    .data_o     (slot_data_s),
    .last_o     (slot_last_s),
    .can_load_o (can_load_s)
  );

  assign bus.s_ready        = s_ready_s;
  assign bus.buf_we         = wr_fire_s;
  assign bus.buf_din        = bus.s_data;
  assign bus.buf_addr       = wr_cnt_q[ADDR_WIDTH-1:0];
  assign bus.buf_reset_done = 1'b0;
  assign bus.buf_rd_en      = rd_en_s;
  assign bus.buf_rd_addr    = rd_cnt_q[ADDR_WIDTH-1:0];
  assign bus.m_valid        = slot_valid_s;
  assign bus.m_data         = slot_data_s;
  assign bus.m_last         = slot_last_s;

  assign busy     = (state_q != ST_IDLE);
  assign row_done = row_done_q;
endmodule

// File: tb/tb_bram_row_sequencer.sv
// Scoreboard bench for bram_row_sequencer: a 4-word row DUT and a 1-word row DUT,
// each with a small behavioural row-buffer model.
module tb_bram_row_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, busy1, row_done0, row_done1, err0, err1;
  bit   stub_done  = 1'b0;
  bit   stall_mode = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  int rows0 = 0, rows1 = 0, outs0 = 0;

  typedef struct { logic [31:0] data; logic last; } out_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; } wr_t;
  out_t exp0_q[$], exp1_q[$];
  wr_t  wexp0_q[$], wexp1_q[$];
  int   stamp_q[$];

  bram_row_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
  bram_row_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

  bram_row_sequencer #(
    .DATA_WIDTH (32), .ADDR_WIDTH (4), .MEM_SIZE (4)
`ifdef ROW_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .start (start0), .bus (bus0),
    .busy (busy0), .row_done (row_done0), .err (err0)
  );

  bram_row_sequencer #(
    .DATA_WIDTH (32), .ADDR_WIDTH (4), .MEM_SIZE (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .start (start1), .bus (bus1),
    .busy (busy1), .row_done (row_done1), .err (err1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Row buffer models: full after MEM_SIZE writes, read_done one cycle after the last read.
  logic [31:0] mem0 [4];
  logic [31:0] mem1;
  int   wcount0;
  logic done0, rdone0, done1, rdone1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcount0 <= 0; done0 <= 1'b0; rdone0 <= 1'b0;
      done1 <= 1'b0; rdone1 <= 1'b0; mem1 <= 32'h0;
    end else begin
      rdone0 <= bus0.buf_rd_en && (bus0.buf_rd_addr == 4'd3);
      if (bus0.buf_we) begin
        mem0[bus0.buf_addr[1:0]] <= bus0.buf_din;
        wcount0 <= wcount0 + 1;
        if (wcount0 == 3) done0 <= 1'b1;
      end
      if (rdone0) begin
        done0 <= 1'b0; wcount0 <= 0;
      end
      rdone1 <= bus1.buf_rd_en;
      if (bus1.buf_we) begin
        mem1 <= bus1.buf_din; done1 <= 1'b1;
      end
      if (rdone1) done1 <= 1'b0;
    end
  end

  assign bus0.buf_done      = done0 && !stub_done;
  assign bus0.buf_dout      = mem0[bus0.buf_rd_addr[1:0]];
  assign bus0.buf_read_done = rdone0;
  assign bus1.buf_done      = done1;
  assign bus1.buf_dout      = mem1;
  assign bus1.buf_read_done = rdone1;

  initial begin
    bus0.m_ready = 1'b1;
    bus1.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus0.m_ready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected writes/outputs whenever the DUTs present them.
  task automatic monitor();
    logic [31:0] prev_data = 32'h0;
    bit   prev_stall = 1'b0;
    out_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus0.buf_we) begin
          if (wexp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: got write %0h expected none", bus0.buf_din);
          end else begin
            w = wexp0_q.pop_front();
            check("wr_addr", bus0.buf_addr, w.addr);
            check("wr_data", bus0.buf_din, w.data);
          end
        end
        if (prev_stall) begin
          check("stall_valid", bus0.m_valid, 64'd1);
          check("stall_data", bus0.m_data, prev_data);
        end
        if (bus0.m_valid && !bus0.m_ready) check("rd_en_stalled", bus0.buf_rd_en, 64'd0);
        if (bus0.m_valid && bus0.m_ready) begin
          if (exp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected: got %0h expected none", bus0.m_data);
          end else begin
            e = exp0_q.pop_front();
            check("out_data", bus0.m_data, e.data);
            check("out_last", bus0.m_last, e.last);
          end
          outs0++;
          stamp_q.push_back(cyc);
        end
        prev_stall = bus0.m_valid && !bus0.m_ready;
        prev_data  = bus0.m_data;
        if (row_done0) rows0++;

        if (bus1.buf_we) begin
          if (wexp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr1_unexpected: got write %0h expected none", bus1.buf_din);
          end else begin
            w = wexp1_q.pop_front();
            check("wr1_addr", bus1.buf_addr, w.addr);
            check("wr1_data", bus1.buf_din, w.data);
          end
        end
        if (bus1.buf_rd_en) check("rd1_addr", bus1.buf_rd_addr, 64'd0);
        if (bus1.m_valid && bus1.m_ready) begin
          if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out1_unexpected: got %0h expected none", bus1.m_data);
          end else begin
            e = exp1_q.pop_front();
            check("out1_data", bus1.m_data, e.data);
            check("out1_last", bus1.m_last, e.last);
          end
        end
        if (row_done1) rows1++;
      end
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1; tick(); start0 = 1'b0;
  endtask

  task automatic feed_row0(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input int gap, input bit mid_start);
    logic [31:0] words [4];
    bit got;
    words = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      if (mid_start && (i == 2)) begin
        start0 = 1'b1; tick(); start0 = 1'b0;
      end
      repeat (gap) tick();
      bus0.s_valid = 1'b1;
      bus0.s_data  = words[i];
      wexp0_q.push_back('{addr: 4'(i), data: words[i]});
      exp0_q.push_back('{data: words[i], last: (i == 3)});
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        got = bus0.s_ready;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL s_ready_timeout: got 0 expected 1 for word %0d", i);
      end
      tick();
      bus0.s_valid = 1'b0;
    end
  endtask

  task automatic wait_idle0(input string name);
    for (int k = 0; k < 200 && busy0; k++) tick();
    if (busy0) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: got busy 1 expected 0", name);
    end
    tick();
  endtask

  task automatic row_checks0(input string name, input int rows_before, input int rows_exp);
    check({name, "_rows"}, 64'(rows0 - rows_before), 64'(rows_exp));
    check({name, "_outq_empty"}, 64'(exp0_q.size()), 64'd0);
    check({name, "_wrq_empty"}, 64'(wexp0_q.size()), 64'd0);
    check({name, "_busy"}, busy0, 64'd0);
  endtask

  initial begin
    int r, o;
    bit got;
    bus0.s_valid = 1'b0; bus0.s_data = 32'h0;
    bus1.s_valid = 1'b0; bus1.s_data = 32'h0;
    fork monitor(); join_none

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", bus0.m_valid, 64'd0);
    check("rst_m_data", bus0.m_data, 64'd0);
    check("rst_m_last", bus0.m_last, 64'd0);
    check("rst_s_ready", bus0.s_ready, 64'd0);
    check("rst_rd_en", bus0.buf_rd_en, 64'd0);
    check("rst_reset_done", bus0.buf_reset_done, 64'd0);
    check("rst_busy", busy0, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: continuous input, full-throughput output
    r = rows0; stamp_q.delete();
    pulse_start0();
    feed_row0(32'h11, 32'h22, 32'h33, 32'h44, 0, 1'b0);
    wait_idle0("t1");
    row_checks0("t1", r, 1);
    if (stamp_q.size() == 4) check("t1_consecutive", 64'(stamp_q[3] - stamp_q[0]), 64'd3);
    else begin
      checks++; errors++;
      $display("FAIL t1_out_count: got %0d expected 4", stamp_q.size());
    end

    // 2: downstream backpressure 1,0,0,...
    r = rows0; stall_mode = 1'b1;
    pulse_start0();
    feed_row0(32'h61, 32'h62, 32'h63, 32'h64, 0, 1'b0);
    wait_idle0("t2");
    row_checks0("t2", r, 1);
    stall_mode = 1'b0;

    // 3: sparse input and a start pulse during FILL
    r = rows0;
    pulse_start0();
    feed_row0(32'h51, 32'h52, 32'h53, 32'h54, 2, 1'b1);
    wait_idle0("t3");
    row_checks0("t3", r, 1);

    // 4: reset after two words have left
    r = rows0; o = outs0;
    pulse_start0();
    feed_row0(32'h71, 32'h72, 32'h73, 32'h74, 0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = (outs0 >= o + 2);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t4_two_outputs: got %0d expected 2", outs0 - o);
    end
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_m_valid", bus0.m_valid, 64'd0);
    check("t4_m_data", bus0.m_data, 64'd0);
    check("t4_m_last", bus0.m_last, 64'd0);
    check("t4_row_done", row_done0, 64'd0);
    check("t4_err", err0, 64'd0);
    check("t4_s_ready", bus0.s_ready, 64'd0);
    check("t4_buf_we", bus0.buf_we, 64'd0);
    check("t4_rd_en", bus0.buf_rd_en, 64'd0);
    check("t4_buf_addr", bus0.buf_addr, 64'd0);
    check("t4_rd_addr", bus0.buf_rd_addr, 64'd0);
    check("t4_busy", busy0, 64'd0);
    exp0_q.delete(); wexp0_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_no_row_done", 64'(rows0 - r), 64'd0);
    r = rows0;
    pulse_start0();
    feed_row0(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1'b0);
    wait_idle0("t4b");
    row_checks0("t4b", r, 1);

`ifdef ROW_SEQ_TIMEOUT_EN
    // 5: buffer never reports full
    r = rows0; stub_done = 1'b1;
    pulse_start0();
    feed_row0(32'h81, 32'h82, 32'h83, 32'h84, 0, 1'b0);
    repeat (7) tick();
    check("t5_err_early", err0, 64'd0);
    check("t5_busy_early", busy0, 64'd1);
    tick();
    check("t5_err", err0, 64'd1);
    check("t5_busy", busy0, 64'd0);
    check("t5_m_valid", bus0.m_valid, 64'd0);
    exp0_q.delete();
    tick();
    check("t5_no_row_done", 64'(rows0 - r), 64'd0);
    check("t5_err_sticky", err0, 64'd1);
    stub_done = 1'b0; r = rows0;
    pulse_start0();
    check("t5_err_cleared", err0, 64'd0);
    feed_row0(32'h91, 32'h92, 32'h93, 32'h94, 0, 1'b0);
    wait_idle0("t5b");
    row_checks0("t5b", r, 1);
`else
    check("err0_tied", err0, 64'd0);
`endif

    // 6: single-word row
    r = rows1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    bus1.s_valid = 1'b1; bus1.s_data = 32'hDEADBEEF;
    wexp1_q.push_back('{addr: 4'd0, data: 32'hDEADBEEF});
    exp1_q.push_back('{data: 32'hDEADBEEF, last: 1'b1});
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus1.s_ready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t6_s_ready_timeout: got 0 expected 1");
    end
    tick();
    bus1.s_valid = 1'b0;
    for (int k = 0; k < 100 && busy1; k++) tick();
    if (busy1) begin
      checks++; errors++;
      $display("FAIL t6_idle_timeout: got busy 1 expected 0");
    end
    tick();
    check("t6_rows", 64'(rows1 - r), 64'd1);
    check("t6_outq_empty", 64'(exp1_q.size()), 64'd0);
    check("t6_wrq_empty", 64'(wexp1_q.size()), 64'd0);
    check("t6_err", err1, 64'd0);
    check("t6_reset_done", bus1.buf_reset_done, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_row_sequencer.md
Name: bram_row_sequencer

Overview:
Master-side controller for one bram_row_modified row buffer in the LSTM datapath.
- Accepts a row of MEM_SIZE words on a valid/ready input stream and drives the buffer write port (addr/din/we).
- Waits for the buffer's full indication, then drives the read port (rd_addr/rd_en) and captures the combinational dout into a registered valid/ready output stream.
- Feeds row data (e.g. weights) to the downstream MAC array.

Parameters:
DATA_WIDTH, 32, word width; must match the buffer.
ADDR_WIDTH, 4, buffer address width.
MEM_SIZE, 4, words per row; 1 <= MEM_SIZE <= 2**ADDR_WIDTH.
TIMEOUT_CYCLES, 64, watchdog limit; used only with ROW_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one row transaction; ignored unless IDLE
s_valid  in  1  input word valid
s_data  in  DATA_WIDTH  input word
s_ready  out  1  input ready
buf_addr  out  ADDR_WIDTH  buffer write address
buf_din  out  DATA_WIDTH  buffer write data
buf_we  out  1  buffer write enable
buf_reset_done  out  1  to buffer reset_done; constant 0
buf_done  in  1  buffer full (done)
buf_rd_addr  out  ADDR_WIDTH  buffer read address
buf_rd_en  out  1  buffer read enable
buf_dout  in  DATA_WIDTH  buffer read data (combinational)
buf_read_done  in  1  buffer read-complete pulse
m_valid  out  1  output word valid
m_data  out  DATA_WIDTH  output word
m_last  out  1  marks final word of row
m_ready  in  1  downstream ready
busy  out  1  state != IDLE
row_done  out  1  one-cycle pulse on return to IDLE after a good row
err  out  1  sticky timeout error; constant 0 without macro

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk):
  - state=IDLE; wr_cnt=rd_cnt=0; rd_done_seen=0.
  - All outputs are 0: m_valid, m_data, m_last, row_done, err, s_ready, buf_we, buf_rd_en, buf_addr, buf_rd_addr.
  - Reset mid-transaction aborts the row with no row_done. The buffer shares rst_n.
- Counters are ADDR_WIDTH+1 bits wide. buf_addr=wr_cnt[ADDR_WIDTH-1:0]; buf_rd_addr=rd_cnt[ADDR_WIDTH-1:0].
- IDLE:
  - s_ready=0.
  - start=1 -> FILL; clear wr_cnt, rd_cnt, rd_done_seen, err.
- FILL:
  - s_ready=1.
  - buf_we=s_valid and buf_din=s_data, both combinational with zero latency.
  - On each handshake wr_cnt++.
  - The handshake with wr_cnt==MEM_SIZE-1 -> WAIT_FULL.
- WAIT_FULL:
  - s_ready=0; buf_we=0.
  - buf_done=1 -> DRAIN. Nominally this takes 1 cycle.
- DRAIN:
  - buf_rd_en = (rd_cnt<MEM_SIZE) && (!m_valid || m_ready). This is the single-entry output slot: one read per cycle at full throughput, with no word lost under backpressure.
  - On buf_rd_en: m_data<=buf_dout, m_valid<=1, m_last<=(rd_cnt==MEM_SIZE-1), rd_cnt++.
  - If m_valid && m_ready with no read issued: m_valid<=0, m_last<=0.
  - After the last read is issued -> WAIT_DONE.
- WAIT_DONE:
  - buf_rd_en=0.
  - rd_done_seen is set on any cycle buf_read_done=1 in DRAIN or WAIT_DONE. The buffer pulses it for only one cycle, so the flag latches it.
  - Exit to IDLE when rd_done_seen=1 and the output slot is empty or draining this cycle (!m_valid || m_ready). On exit, row_done=1 for one cycle.
- buf_din is don't-care when buf_we=0; it is driven with s_data regardless.
- start during busy is ignored.
- s_valid outside FILL is ignored; no data is accepted.
- MEM_SIZE=1: FILL takes one handshake; the single output word has m_last=1.
- m_data/m_last hold stable while m_valid && !m_ready.

Optional Feature:
Macro ROW_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT_FULL and WAIT_DONE and clears on entry to either state.
  - On reaching TIMEOUT_CYCLES: err<=1 (sticky until next accepted start), state -> IDLE, no row_done, m_valid cleared.
- Undefined:
  - No counter logic; err tied 0; both wait states wait indefinitely.

Decomposition:
- Shared package lstm_row_pkg holds:
  - state encoding localparams (IDLE=0, FILL=1, WAIT_FULL=2, DRAIN=3, WAIT_DONE=4; 3-bit);
  - a count-width constant function (ADDR_WIDTH+1).
- One sub-module is natural: row_seq_out_slot. It is the single-entry output register with the load/accept/hold logic, and it exposes an "can_load" signal used for buf_rd_en.

Test Plan:
1. MEM_SIZE=4. start; feed 0x11,0x22,0x33,0x44 with s_valid continuous; m_ready=1 -> buffer writes addr 0..3; four output words 0x11..0x44 on consecutive cycles; m_last only on 0x44; row_done pulse once; busy low afterwards.
2. Same row with m_ready toggling 1,0,0,1,... -> buf_rd_en never high while the slot is full and unaccepted; all 4 words delivered in order; m_data stable across stall cycles.
3. s_valid gaps (word every 3rd cycle) plus start pulsed again mid-FILL -> wr_cnt advances only on handshakes; second start has no effect; output data correct.
4. Assert rst_n low for 1 cycle after 2 words are output -> all outputs 0 immediately; no row_done; a fresh start then completes a full row 0xA0..0xA3.
5. ROW_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8; stub buf_done stuck 0 -> err=1 after 8 WAIT_FULL cycles; state IDLE; no m_valid. Next start clears err.
6. MEM_SIZE=1, single word 0xDEADBEEF -> one output with m_last=1; row_done pulse.
